// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams 32-bit words into byte-wide instruction memory, big-endian
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_written
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [ADDR_W+1:0] MEM_BYTES = (ADDR_W+2)'(1) << ADDR_W;

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  rem;
  logic [31:0]       word;
  logic [1:0]        idx;
  logic [ADDR_W+1:0] base_al;
  logic [ADDR_W+1:0] end_addr;

  // One past the last byte of the requested load, wide enough not to overflow
  assign base_al  = {2'b00, base_addr[ADDR_W-1:2], 2'b00};
  assign end_addr = base_al + ((ADDR_W+2)'(word_count) << 2);

  assign in_ready = (state == S_WAIT);
  assign mem_we   = (state == S_WRITE);
  assign busy     = (state == S_WAIT) || (state == S_WRITE);
  assign cpu_hold = busy;
  assign done     = (state == S_DONE);
  assign mem_addr = ptr;

  always_comb begin
    mem_wdata = word[31:24];
    case (idx)
      2'd0: mem_wdata = word[31:24];
      2'd1: mem_wdata = word[23:16];
      2'd2: mem_wdata = word[15:8];
      2'd3: mem_wdata = word[7:0];
      default: mem_wdata = word[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      rem           <= '0;
      word          <= '0;
      idx           <= '0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            error         <= 1'b0;
            words_written <= '0;
            if (word_count == '0) begin
              state <= S_DONE;
            end else if (end_addr > MEM_BYTES) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              ptr   <= {base_addr[ADDR_W-1:2], 2'b00};
              rem   <= word_count;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            word  <= in_data;
            idx   <= 2'd0;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            words_written <= words_written + 1'b1;
            rem           <= rem - 1'b1;
            // Hold ptr after the final byte so it never wraps past the top of memory
            if (rem == CNT_W'(1)) begin
              state <= S_DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= S_WAIT;
            end
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [6:0] word_count = '0;
  logic       in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic       in_ready, mem_we, busy, cpu_hold, done, error;
  logic [7:0] mem_addr, mem_wdata;
  logic [6:0] words_written;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_count = 0;
  logic [7:0] exp_ptr;
  logic [7:0] sb_addr[$];
  logic [7:0] sb_data[$];

  imem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .cpu_hold(cpu_hold), .done(done),
    .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Every byte write is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      total_cnt++;
      if (sb_addr.size() == 0) begin
        $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        logic [7:0] ea, ed;
        ea = sb_addr.pop_front();
        ed = sb_data.pop_front();
        if (mem_addr !== ea || mem_wdata !== ed)
          $display("FAIL mem_write got %h:%h expected %h:%h", mem_addr, mem_wdata, ea, ed);
        else
          pass_cnt++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] b, input logic [6:0] c);
    start = 1'b1;
    base_addr = b;
    word_count = c;
    exp_ptr = {b[7:2], 2'b00};
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input int nbytes);
    int t;
    if (gap > 0) begin
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      repeat (gap) begin
        total_cnt++;
        if (in_ready !== 1'b1 || mem_we !== 1'b0)
          $display("FAIL gap_idle in_ready=%b mem_we=%b expected 1/0", in_ready, mem_we);
        else
          pass_cnt++;
        @(negedge clk);
      end
    end
    for (int b = 0; b < nbytes; b++) begin
      sb_addr.push_back(exp_ptr);
      sb_data.push_back(w[31-8*b -: 8]);
      exp_ptr++;
    end
    in_valid = 1'b1;
    in_data = w;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      total_cnt++;
      $display("FAIL accept_timeout in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [6:0] exp_ww);
    int t = 0;
    while (!done && t < 100) begin @(negedge clk); t++; end
    total_cnt++;
    if (!done) $display("FAIL done_timeout done=%b expected 1", done);
    else pass_cnt++;
    total_cnt++;
    if (words_written !== exp_ww || error !== 1'b0 || sb_addr.size() != 0)
      $display("FAIL done_state ww=%0d err=%b pending=%0d expected %0d/0/0",
               words_written, error, sb_addr.size(), exp_ww);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_pulse done=%b busy=%b expected 0/0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({in_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0 ||
        mem_addr !== 8'h00 || mem_wdata !== 8'h00 || words_written !== 7'd0)
      $display("FAIL reset_state flags=%b addr=%h data=%h ww=%0d expected all 0",
               {in_ready, mem_we, busy, cpu_hold, done, error}, mem_addr, mem_wdata, words_written);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    start_load(8'h00, 7'd2);
    total_cnt++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL b2b_busy busy=%b hold=%b rdy=%b expected 1/1/1", busy, cpu_hold, in_ready);
    else pass_cnt++;
    send_word(32'hE3A01005, 0, 4);
    total_cnt++;
    if (mem_we !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL first_write_latency mem_we=%b in_ready=%b expected 1/0", mem_we, in_ready);
    else pass_cnt++;
    send_word(32'hE2811001, 0, 4);
    wait_done(7'd2);
  endtask

  task automatic test_gap();
    start_load(8'h00, 7'd2);
    send_word(32'hE3A01005, 0, 4);
    send_word(32'hE2811001, 3, 4);
    wait_done(7'd2);
  endtask

  task automatic test_range();
    int wc;
    start_load(8'hF8, 7'd2);
    send_word(32'h11223344, 0, 4);
    send_word(32'h55667788, 0, 4);
    wait_done(7'd2);
    wc = we_count;
    start_load(8'hFC, 7'd2);
    repeat (6) begin
      total_cnt++;
      if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL range_error err=%b busy=%b done=%b expected 1/0/0", error, busy, done);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (we_count != wc) $display("FAIL range_no_write writes=%0d expected %0d", we_count, wc);
    else pass_cnt++;
  endtask

  task automatic test_zero_count();
    int wc = we_count;
    start_load(8'h30, 7'd0);
    total_cnt++;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_done done=%b err=%b busy=%b expected 1/0/0", done, error, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || we_count != wc)
      $display("FAIL zero_pulse done=%b writes=%0d expected 0/%0d", done, we_count, wc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    start_load(8'h20, 7'd1);
    send_word(32'hA1B2C3D4, 0, 3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || words_written !== 7'd0 ||
        mem_addr !== 8'h00 || sb_addr.size() != 0)
      $display("FAIL mid_reset we=%b busy=%b rdy=%b ww=%0d addr=%h pending=%0d expected 0/0/0/0/00/0",
               mem_we, busy, in_ready, words_written, mem_addr, sb_addr.size());
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    start_load(8'h10, 7'd1);
    send_word(32'hDEADBEEF, 0, 4);
    wait_done(7'd1);
  endtask

  task automatic test_start_while_busy();
    start_load(8'h40, 7'd2);
    send_word(32'h01020304, 0, 4);
    start = 1'b1;
    base_addr = 8'h80;
    word_count = 7'd1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'h05060708, 0, 4);
    wait_done(7'd2);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || words_written !== 7'd2)
      $display("FAIL busy_start_ignored busy=%b ww=%0d expected 0/2", busy, words_written);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_range();
    test_zero_count();
    test_reset_mid_load();
    test_start_while_busy();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
